// File: rtl/des_pkg.sv
// DES key-schedule constants shared by the forward and inverse schedules.
// Bit numbering: DES bit 1 is the MSB of every vector.
package des_pkg;

  localparam int DES_KEY_W  = 56;
  localparam int DES_RKEY_W = 48;
  localparam int DES_HALF_W = 28;

  // Controller states of the inverse schedule
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // PC-2 selection: entry i gives the 1-based DES bit of C||D that becomes
  // round-key bit i+1.
  localparam int unsigned PC2 [DES_RKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Right-rotation amounts for decrypt order. Entry 0 is zero because
  // C16||D16 equals C0||D0 (forward shifts sum to 28).
  localparam logic [1:0] SHIFT_INV [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

endpackage

// File: rtl/key_schedule_inv_step.sv
// Combinational step of the inverse schedule: PC-2 of the current state and
// the right-rotated state for the next round.
module key_schedule_inv_step
  import des_pkg::*;
(
  input  logic [DES_KEY_W-1:0]  cs,
  input  logic [1:0]            s,
  output logic [DES_KEY_W-1:0]  r,
  output logic [DES_RKEY_W-1:0] k
);

  logic [DES_HALF_W-1:0] c;
  logic [DES_HALF_W-1:0] d;
  logic [DES_HALF_W-1:0] c_rot;
  logic [DES_HALF_W-1:0] d_rot;

  assign c = cs[DES_KEY_W-1:DES_HALF_W];
  assign d = cs[DES_HALF_W-1:0];

  // Rotate each 28-bit half right by s (toward higher DES bit numbers)
  always_comb begin
    c_rot = c;
    d_rot = d;
    case (s)
      2'd0: begin
        c_rot = c;
        d_rot = d;
      end
      2'd1: begin
        c_rot = {c[0], c[DES_HALF_W-1:1]};
        d_rot = {d[0], d[DES_HALF_W-1:1]};
      end
      2'd2: begin
        c_rot = {c[1:0], c[DES_HALF_W-1:2]};
        d_rot = {d[1:0], d[DES_HALF_W-1:2]};
      end
      default: begin
        c_rot = {c[2:0], c[DES_HALF_W-1:3]};
        d_rot = {d[2:0], d[DES_HALF_W-1:3]};
      end
    endcase
  end

  assign r = {c_rot, d_rot};

  // PC-2 is pure wiring: round-key bit gi+1 picks DES bit PC2[gi] of cs
  generate
    for (genvar gi = 0; gi < DES_RKEY_W; gi++) begin : g_pc2
      assign k[DES_RKEY_W-1-gi] = cs[DES_KEY_W-PC2[gi]];
    end
  endgenerate

endmodule

// File: rtl/key_schedule_inv.sv
// Sequential DES decryption key schedule: emits K16..K1 over a valid/ready
// stream from the post-PC-1 state C0||D0.
module key_schedule_inv
  import des_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [DES_KEY_W-1:0]  x,
  output logic                  busy,
  output logic [DES_RKEY_W-1:0] k,
  output logic                  k_valid,
  input  logic                  k_ready,
  output logic [3:0]            k_idx,
  output logic                  done
);

  state_t               state;
  logic [DES_KEY_W-1:0] cs;
  logic [3:0]           rnd;
  logic [3:0]           rnd_inc;
  logic [1:0]           s_next;
  logic [DES_KEY_W-1:0] cs_rot;

  assign rnd_inc = rnd + 4'd1;
  // Rotation applied when leaving round rnd belongs to round rnd+1
  assign s_next  = SHIFT_INV[rnd_inc];

  key_schedule_inv_step u_step (
    .cs (cs),
    .s  (s_next),
    .r  (cs_rot),
    .k  (k)
  );

  assign busy    = (state != IDLE);
  assign k_valid = (state == EMIT);
  assign k_idx   = rnd;

  // FSM, key-state and round registers; the held state only advances on a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cs    <= '0;
      rnd   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle still belongs to the finished run; a new request
          // is taken from the following cycle on.
          if (req && !done) begin
            cs    <= x;
            rnd   <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (k_ready) begin
            if (rnd == 4'd15) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              rnd <= rnd_inc;
              cs  <= cs_rot;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_inv.sv
// Directed bench for the inverse DES key schedule.
module tb_key_schedule_inv;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [55:0] x;
  logic        busy;
  logic [47:0] k;
  logic        k_valid;
  logic        k_ready;
  logic [3:0]  k_idx;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [55:0] X1  = 56'hF0CCAAF556678F;
  localparam logic [55:0] X2  = 56'h123456789ABCDE;

  // Independent copy of the PC-2 table
  localparam int unsigned TB_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  // Forward (encrypt) left-rotation amounts
  localparam int unsigned TB_SHL [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  key_schedule_inv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .x       (x),
    .busy    (busy),
    .k       (k),
    .k_valid (k_valid),
    .k_ready (k_ready),
    .k_idx   (k_idx),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] tb_pc2(input logic [55:0] v);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = v[56-TB_PC2[i]];
    return o;
  endfunction

  // Forward schedule: key K(n+1) for n = 0..15
  function automatic logic [47:0] fwd_key(input logic [55:0] v, input int n);
    logic [27:0] c, d;
    c = v[55:28];
    d = v[27:0];
    for (int i = 0; i <= n; i++) begin
      for (int j = 0; j < TB_SHL[i]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    end
    return tb_pc2({c, d});
  endfunction

  logic [47:0] first_k, last_k;
  int          done_cyc;

  // One full run: req pulse, optional random stalls, optional req/x glitching
  task automatic run_seq(input logic [55:0] xv, input bit stall, input bit glitch);
    int acc;
    int cyc;
    acc = 0;
    done_cyc = 0;
    first_k = '0;
    last_k = '0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        req = 1'b1;
        x   = xv;
      end else if (glitch && cyc > 2) begin
        req = $urandom_range(0, 1);
        x   = X2 ^ 56'($urandom);
      end else begin
        req = 1'b0;
      end
      k_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (k_valid) begin
        chk("k_idx", 64'(k_idx), 64'(acc));
        chk("k", 64'(k), 64'(fwd_key(xv, 15 - acc)));
        chk("busy_emit", 64'(busy), 64'd1);
        if (acc == 0) first_k = k;
        if (acc == 15) last_k = k;
        if (k_ready) begin
          $display("key idx=%0d k=%h", k_idx, k);
          acc++;
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    req = 1'b0;
    chk("accepts", 64'(acc), 64'd16);
    chk("done_seen", 64'(done_cyc != 0), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("kvalid_at_done", 64'(k_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0;
    x = '0;
    k_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_kvalid", 64'(k_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_kidx", 64'(k_idx), 64'd0);
    chk("rst_k", 64'(k), 64'd0);
    rst_n = 1'b1;

    // Back-to-back with the reference key
    run_seq(X1, 1'b0, 1'b0);
    chk("k16", 64'(first_k), 64'h0000_CB3D8B0E17F5);
    chk("k1", 64'(last_k), 64'h0000_1B02EFFC7072);
    chk("done_cycle", 64'(done_cyc), 64'd18);

    // Random stalls
    run_seq(X1, 1'b1, 1'b0);
    chk("stall_k1", 64'(last_k), 64'h0000_1B02EFFC7072);

    // req/x disturbances during EMIT are ignored
    run_seq(X1, 1'b1, 1'b1);
    chk("glitch_k16", 64'(first_k), 64'h0000_CB3D8B0E17F5);

    // Extreme keys
    run_seq(56'h0, 1'b0, 1'b0);
    chk("zero_k", 64'(first_k | last_k), 64'h0);
    run_seq(56'hFFFFFFFFFFFFFF, 1'b0, 1'b0);
    chk("ones_k", 64'(first_k & last_k), 64'h0000_FFFFFFFFFFFF);

    // Asynchronous reset at k_idx=7
    @(posedge clk);
    #1;
    req = 1'b1;
    x = X1;
    k_ready = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (k_valid && k_idx == 4'd7) break;
      @(posedge clk);
      #1;
    end
    chk("pre_rst_idx", 64'(k_idx), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_kvalid", 64'(k_valid), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_kidx", 64'(k_idx), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'(k_valid), 64'd0);
    run_seq(X1, 1'b0, 1'b0);
    chk("restart_k16", 64'(first_k), 64'h0000_CB3D8B0E17F5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
